// File: rtl/ch5_pkg.sv
// ============================================================================
// Module   : ch5_pkg
// Purpose  : Shared types and constants for the chapter-5 "three consecutive
//            ones" detector family and its stimulus transmitter.
// Contents : tx_state_t        transmitter FSM states
//            RUN_TARGET        run length at which the detector fires
//            RUN_W / RUN_MAX   run-counter width and saturation value
//            GAP_W             width of the inter-word gap counter
//            run_sat_inc()     saturating increment of a run count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ch5_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  localparam int RUN_TARGET = 3;
  localparam int RUN_W      = 2;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_TARGET);

  // Holds GAP_CYCLES up to 15.
  localparam int GAP_W = 4;

  // Count one more 1 in the current run, holding at RUN_MAX.
  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] run);
    return (run == RUN_MAX) ? run : run + RUN_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ones_run_model.sv
// ============================================================================
// Module   : ones_run_model
// Purpose  : Saturating run tracker that predicts the output of a Moore
//            "three consecutive 1s" detector clocked by the same clock and
//            fed the same bit stream. Usable as a golden model for any
//            detector in the family.
// Ports    : clk       in   clock, rising edge
//            rst       in   asynchronous reset, active low
//            x         in   serial bit stream seen by the detector
//            expect_y  out  predicted detector output (registered)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ones_run_model
  import ch5_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic expect_y
);

  // r_run 0..3 is the detector state 00/01/10/11.
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_next;

  always_comb begin
    w_run_next = x ? run_sat_inc(r_run) : '0;
  end

  // expect_y is registered from the next-state value so that it equals
  // (r_run == RUN_MAX) in every cycle, exactly like the detector's Moore y.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run    <= '0;
      expect_y <= 1'b0;
    end else begin
      r_run    <= w_run_next;
      expect_y <= (w_run_next == RUN_MAX);
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_pattern_tx.sv
// ============================================================================
// Module   : serial_pattern_tx
// Purpose  : Loads a parallel word through a valid/ready handshake and shifts
//            it out MSB first, one bit per clock, followed by at least one
//            idle zero (plus GAP_CYCLES more). Also predicts the output of a
//            "three consecutive 1s" detector driven by the same stream.
// Params   : WIDTH       word length, 2..32
//            GAP_CYCLES  extra zero bits after each word, 0..15
// Ports    : clk         in   clock, rising edge
//            rst         in   asynchronous reset, active low
//            data_in     in   word to send, sampled on an accepted load
//            load_valid  in   source offers data_in
//            load_ready  out  ready to accept a word (IDLE only)
//            x           out  serial bit, 0 when not shifting
//            x_valid     out  x carries a word bit
//            done        out  pulse coincident with the last bit
//            expect_y    out  predicted detector output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_pattern_tx
  import ch5_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic             expect_y
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(WIDTH - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  tx_state_t        r_state;
  // Holds only the bits not yet placed on x, left-aligned, so the next bit
  // to send is always the MSB.
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;  // index of the bit currently on x
  logic [GAP_W-1:0] r_gap_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      load_ready <= 1'b1;
      x          <= 1'b0;
      x_valid    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // load_ready is 1 throughout IDLE, so load_valid alone accepts.
          if (load_valid) begin
            r_state    <= SHIFT;
            load_ready <= 1'b0;
            r_shift    <= {data_in[WIDTH-2:0], 1'b0};
            r_bit_cnt  <= '0;
            x          <= data_in[WIDTH-1];
            x_valid    <= 1'b1;
            done       <= 1'b0;
          end
        end

        SHIFT: begin
          if (r_bit_cnt == BIT_LAST) begin
            x         <= 1'b0;
            x_valid   <= 1'b0;
            done      <= 1'b0;
            r_gap_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              r_state <= GAP;
            end else begin
              r_state    <= IDLE;
              load_ready <= 1'b1;
            end
          end else begin
            x         <= r_shift[WIDTH-1];
            r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            done      <= (r_bit_cnt == DONE_AT);
          end
        end

        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state    <= IDLE;
            load_ready <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          r_state    <= IDLE;
          load_ready <= 1'b1;
          x          <= 1'b0;
          x_valid    <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  ones_run_model u_run_model (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .expect_y (expect_y)
  );

endmodule

`default_nettype wire
